qacc: RTL and testbench



---
 rtl/qacc_pkg.sv | 19 +
 rtl/qacc_lane.sv | 60 ++++++
 rtl/qacc.sv | 108 ++++++++++
 tb/tb_qacc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/qacc_pkg.sv
// rtl/qacc_pkg.sv - shared FSM state type and saturation bounds for qacc
package qacc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   // Largest value representable in an ab-bit two's complement word.
   function automatic longint sat_max(input int ab);
      return (longint'(1) <<< (ab - 1)) - longint'(1);
   endfunction

   // Smallest value representable in an ab-bit two's complement word.
   function automatic longint sat_min(input int ab);
      return -(longint'(1) <<< (ab - 1));
   endfunction

endpackage

// File: rtl/qacc_lane.sv
// rtl/qacc_lane.sv - one lane: signed multiply, extend, saturating accumulate, sticky flag
module qacc_lane
   import qacc_pkg::*;
#(
   parameter int XB = 8,
   parameter int WB = 8,
   parameter int AB = 24
)
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          accept,
   input  logic          last,
   input  logic [XB-1:0] x,
   input  logic [WB-1:0] w,
   output logic [AB-1:0] res,
   output logic          res_sat
);

   localparam logic signed [AB-1:0] MAXV = AB'(sat_max(AB));
   localparam logic signed [AB-1:0] MINV = AB'(sat_min(AB));

   logic signed [AB-1:0]      acc;
   logic                      sat;
   logic signed [XB+WB-1:0]   prod;
   logic signed [AB:0]        sum;
   logic                      ovf;

   // Full-precision product, then both operands sign-extended by one guard bit
   // so a single add can never wrap; the guard bit exposes overflow.
   assign prod = $signed(x) * $signed(w);
   assign sum  = (AB+1)'(acc) + (AB+1)'(prod);
   assign ovf  = sum[AB] ^ sum[AB-1];

   // Clamp to the AB-bit range; the guard bit gives the overflow direction.
   always_comb begin
      res     = sum[AB-1:0];
      res_sat = sat | ovf;
      if (ovf) begin
         res = sum[AB] ? MINV : MAXV;
      end
   end

   // Running sum and sticky flag; a last beat hands its result out and restarts at zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (accept) begin
         if (last) begin
            acc <= '0;
            sat <= 1'b0;
         end else begin
            acc <= res;
            sat <= res_sat;
         end
      end
   end

endmodule

// File: rtl/qacc.sv
// rtl/qacc.sv - N-lane signed multiply-accumulate with saturation and beat-count error
module qacc
   import qacc_pkg::*;
#(
   parameter int N    = 1,
   parameter int XB   = 8,
   parameter int WB   = 8,
   parameter int AB   = 24,
   parameter int KMAX = 1024
)
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [N*XB-1:0] s_x,
   input  logic [N*WB-1:0] s_w,
   input  logic            s_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [N*AB-1:0] m_data,
   output logic [N-1:0]    m_sat,
   output logic            m_err
);

   localparam int            KB     = $clog2(KMAX + 1);
   localparam logic [KB-1:0] KMAX_C = KB'(KMAX);

   state_t          state;
   state_t          state_next;
   logic            accept;
   logic            vec_end;
   logic [KB-1:0]   count;
   logic [N*AB-1:0] lane_res;
   logic [N-1:0]    lane_sat;

   // A new beat may enter whenever the output slot is empty or being drained
   // this cycle, which lets consecutive results stream without a bubble.
   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;
   assign vec_end = accept && s_last;

   for (genvar i = 0; i < N; i++) begin : g_lane
      qacc_lane #(
         .XB (XB),
         .WB (WB),
         .AB (AB)
      ) u_lane (
         .clk     (clk),
         .rstn    (rstn),
         .accept  (accept),
         .last    (s_last),
         .x       (s_x[i*XB +: XB]),
         .w       (s_w[i*WB +: WB]),
         .res     (lane_res[i*AB +: AB]),
         .res_sat (lane_sat[i])
      );
   end

   // Vector state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // IDLE waits for the first beat of a vector; ACC runs until the last beat.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept && !s_last) state_next = ACC;
         ACC:  if (accept && s_last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Beats already taken in the current vector, pinned at KMAX so it cannot wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (vec_end) begin
         count <= '0;
      end else if (accept && (count != KMAX_C)) begin
         count <= count + 1'b1;
      end
   end

   // Result register: loads on a last beat, otherwise holds until drained.
   // count still excludes the last beat, so reaching KMAX here means KMAX+1 or more beats.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sat   <= '0;
         m_err   <= 1'b0;
      end else if (vec_end) begin
         m_valid <= 1'b1;
         m_data  <= lane_res;
         m_sat   <= lane_sat;
         m_err   <= (count == KMAX_C);
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_qacc.sv
// tb/tb_qacc.sv - directed self-checking bench for qacc
module tb_qacc;

   localparam int N    = 2;
   localparam int XB   = 8;
   localparam int WB   = 8;
   localparam int AB   = 16;
   localparam int KMAX = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [N*XB-1:0] s_x = '0;
   logic [N*WB-1:0] s_w = '0;
   logic            s_last = 1'b0;
   logic            m_valid;
   logic            m_ready = 1'b1;
   logic [N*AB-1:0] m_data;
   logic [N-1:0]    m_sat;
   logic            m_err;

   logic            d1_ready;
   logic            d1_valid;
   logic [23:0]     d1_data;
   logic [0:0]      d1_sat;
   logic            d1_err;

   int n_checks = 0;
   int n_fails  = 0;

   qacc #(.N(N), .XB(XB), .WB(WB), .AB(AB), .KMAX(KMAX)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_x     (s_x),
      .s_w     (s_w),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_sat   (m_sat),
      .m_err   (m_err)
   );

   qacc d1 (
      .clk     (clk),
      .rstn    (rstn),
      .s_valid (s_valid),
      .s_ready (d1_ready),
      .s_x     (s_x[7:0]),
      .s_w     (s_w[7:0]),
      .s_last  (s_last),
      .m_valid (d1_valid),
      .m_ready (m_ready),
      .m_data  (d1_data),
      .m_sat   (d1_sat),
      .m_err   (d1_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_beat(input int x0, input int w0, input int x1, input int w1, input bit last);
      s_valid = 1'b1;
      s_x     = {8'(x1), 8'(x0)};
      s_w     = {8'(w1), 8'(w0)};
      s_last  = last;
   endtask

   task automatic drive(input int x0, input int w0, input int x1, input int w1, input bit last);
      set_beat(x0, w0, x1, w1, last);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic check_res(input string tag, input int l0, input int l1, input int sat, input int err);
      check({tag, "_valid"}, m_valid, 1);
      check({tag, "_l0"}, $signed(m_data[15:0]), l0);
      check({tag, "_l1"}, $signed(m_data[31:16]), l1);
      check({tag, "_sat"}, m_sat, sat);
      check({tag, "_err"}, m_err, err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_sat", m_sat, 0);
      check("rst_err", m_err, 0);
      check("rst_ready", s_ready, 1);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      drive(3, 4, -3, 4, 0);
      drive(-2, 5, 2, 5, 0);
      drive(7, -1, -7, -1, 1);
      check_res("mac3", -5, 5, 0, 0);
      check("mac3_d1", $signed(d1_data), -5);
      @(posedge clk);
      #1;
      check("mac3_drain", m_valid, 0);

      drive(127, 127, -127, 127, 1);
      check_res("one", 16129, -16129, 0, 0);
      drive(1, 1, 1, 1, 1);
      check_res("fresh", 1, 1, 0, 0);

      drive(127, 127, -127, 127, 0);
      drive(127, 127, -127, 127, 0);
      drive(127, 127, -127, 127, 0);
      drive(-128, 127, 127, 127, 1);
      check_res("satur", 16511, -16639, 3, 0);
      check("satur_d1", $signed(d1_data), 32131);
      check("satur_d1sat", d1_sat, 0);
      drive(2, 3, 2, 3, 1);
      check_res("unsat", 6, 6, 0, 0);
      @(posedge clk);
      #1;

      m_ready = 1'b0;
      drive(1, 2, 3, 4, 1);
      check_res("stall", 2, 12, 0, 0);
      set_beat(5, 5, 5, 5, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_ready", s_ready, 0);
         check("hold_valid", m_valid, 1);
         check("hold_data", m_data, {16'd12, 16'd2});
      end
      m_ready = 1'b1;
      #1;
      check("release_ready", s_ready, 1);
      drive(5, 5, 5, 5, 1);
      check_res("b2b_a", 25, 25, 0, 0);
      drive(2, 2, -2, 2, 1);
      check_res("b2b_b", 4, -4, 0, 0);

      for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 1);
      check_res("over", 6, 6, 0, 1);
      check("over_d1err", d1_err, 0);
      check("over_d1", $signed(d1_data), 6);
      for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 1);
      check_res("kmax", 4, 4, 0, 0);

      drive(9, 9, 9, 9, 0);
      drive(9, 9, 9, 9, 0);
      rstn = 1'b0;
      #1;
      check("arst_valid", m_valid, 0);
      check("arst_data", m_data, 0);
      check("arst_sat", m_sat, 0);
      check("arst_err", m_err, 0);
      check("arst_d1", d1_data, 0);
      #1;
      rstn = 1'b1;
      drive(1, 1, 1, 1, 0);
      drive(1, 1, 1, 1, 1);
      check_res("post_rst", 2, 2, 0, 0);
      check("post_rst_d1", $signed(d1_data), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
